// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives word reads to instruction memory, buffers {pc, instr} in a small FIFO,
// and flushes on redirect. Define INSTR_FETCH_PERF_EN to add the fetch_count_o pop counter.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i
`ifdef INSTR_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count_o
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic               mem_req_q, mem_req_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;

  logic [31:0]        instr_mem [FIFO_DEPTH];
  logic [31:0]        pc_mem    [FIFO_DEPTH];

  logic               push;
  logic               pop;
  logic               free;

  assign instr_valid_o = (count_q != '0);
  assign instr_o       = instr_valid_o ? instr_mem[rd_ptr_q] : 32'h0;
  assign pc_o          = instr_valid_o ? pc_mem[rd_ptr_q]    : 32'h0;
  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = mem_addr_q;

  // A redirect kills both the head being offered and any response landing this cycle.
  assign pop  = instr_valid_o && instr_ready_i && !redirect_i;
  assign push = (state_q == S_REQ) && mem_ack_i && !redirect_i;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_i) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign free = (count_d < CNT_W'(FIFO_DEPTH));

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      S_IDLE: begin
        mem_req_d = 1'b0;
        if (redirect_i) fetch_pc_d = redirect_pc_i;
        if (free) begin
          state_d    = S_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_d;
        end
      end
      S_REQ: begin
        if (mem_ack_i) begin
          if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            mem_addr_d = redirect_pc_i;
            mem_req_d  = 1'b1;
          end else begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            if (free) begin
              mem_addr_d = fetch_pc_d;
              mem_req_d  = 1'b1;
            end else begin
              state_d   = S_IDLE;
              mem_req_d = 1'b0;
            end
          end
        end else if (redirect_i) begin
          // Old request stays on the bus until its ack arrives; that data is dropped.
          fetch_pc_d = redirect_pc_i;
          state_d    = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (redirect_i) fetch_pc_d = redirect_pc_i;
        if (mem_ack_i) begin
          state_d    = S_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_d;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Buffer storage carries no reset; the outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= mem_rdata_i;
      pc_mem[wr_ptr_q]    <= fetch_pc_q;
    end
  end

`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count_q <= 32'h0;
    end else if (pop) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count_o = fetch_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a memory responder and a {pc, instr} scoreboard.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] fetch_count;
`endif

  int          checks   = 0;
  int          failures = 0;
  int          pops     = 0;
  ent_t        sb[$];
  logic [31:0] exp_pc;
  logic [31:0] disc_addr;
  bit          discard;
  bit          auto_ack;
  bit          force_ack;
  bit          bad_data;

  instruction_fetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i)
`ifdef INSTR_FETCH_PERF_EN
    ,
    .fetch_count_o (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_1357;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge with this cycle's inputs already set.
  task automatic cyc();
    logic ack;
    ent_t e;
    ack = mem_req_o && (auto_ack || force_ack);
    mem_ack_i   = ack;
    mem_rdata_i = ack ? (bad_data ? 32'hDEAD_BEEF : word_of(mem_addr_o)) : 32'h0;
    if (instr_valid_o && instr_ready_i && !redirect_i) begin
      pops++;
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL pop_unexpected observed pc=%h instr=%h expected no entry", pc_o, instr_o);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pop_pc", pc_o, e.pc);
        chk("pop_instr", instr_o, e.instr);
      end
    end
    if (ack) begin
      chk("req_addr", mem_addr_o, discard ? disc_addr : exp_pc);
      if (redirect_i) begin
        exp_pc  = redirect_pc_i;
        discard = 1'b0;
      end else if (discard) begin
        discard = 1'b0;
      end else begin
        e.pc    = exp_pc;
        e.instr = word_of(exp_pc);
        sb.push_back(e);
        exp_pc += 32'd4;
      end
    end else if (redirect_i) begin
      if (mem_req_o && !discard) begin
        disc_addr = exp_pc;
        discard   = 1'b1;
      end
      exp_pc = redirect_pc_i;
    end
    if (redirect_i) sb.delete();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    mem_ack_i  = 1'b0;
    redirect_i = 1'b0;
    auto_ack   = 1'b0;
    force_ack  = 1'b0;
    bad_data   = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    sb.delete();
    exp_pc  = RESET_PC;
    discard = 1'b0;
    pops    = 0;
    chk("rst_req", 32'(mem_req_o), 32'h0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_valid", 32'(instr_valid_o), 32'h0);
  endtask

  initial begin
    rst_n         = 1'b0;
    mem_ack_i     = 1'b0;
    mem_rdata_i   = 32'h0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    instr_ready_i = 1'b0;
    auto_ack      = 1'b0;
    force_ack     = 1'b0;
    bad_data      = 1'b0;
    discard       = 1'b0;
    exp_pc        = RESET_PC;
    disc_addr     = 32'h0;
    @(negedge clk);

    // Streaming with single-cycle memory and ready=1
    do_reset();
    instr_ready_i = 1'b1;
    auto_ack      = 1'b1;
    cyc();
    chk("t1_first_req", 32'(mem_req_o), 32'h1);
    chk("t1_valid_before_ack", 32'(instr_valid_o), 32'h0);
    cyc();
    chk("t1_valid_after_ack", 32'(instr_valid_o), 32'h1);
    chk("t1_first_pc", pc_o, RESET_PC);
    for (int i = 0; i < 8; i++) cyc();
    chk("t1_pop_rate", 32'(pops), 32'd8);

    // Back-pressure: fill, hold, then drain
    do_reset();
    instr_ready_i = 1'b0;
    auto_ack      = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    chk("t2_req_dropped", 32'(mem_req_o), 32'h0);
    chk("t2_valid", 32'(instr_valid_o), 32'h1);
    chk("t2_hold_pc", pc_o, 32'h0);
    chk("t2_hold_instr", instr_o, word_of(32'h0));
    cyc();
    cyc();
    chk("t2_hold_pc_later", pc_o, 32'h0);
    chk("t2_still_idle", 32'(mem_req_o), 32'h0);
    instr_ready_i = 1'b1;
    cyc();
    chk("t2_reissue_req", 32'(mem_req_o), 32'h1);
    chk("t2_reissue_addr", mem_addr_o, 32'h8);
    for (int i = 0; i < 3; i++) cyc();

    // Redirect while a request is pending; late ack is discarded
    do_reset();
    instr_ready_i = 1'b1;
    auto_ack      = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    auto_ack = 1'b0;
    chk("t3_pending_addr", mem_addr_o, 32'h8);
    chk("t3_head_present", 32'(instr_valid_o), 32'h1);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    cyc();
    redirect_i = 1'b0;
    chk("t3_flushed", 32'(instr_valid_o), 32'h0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("t3_wait_valid", 32'(instr_valid_o), 32'h0);
      chk("t3_wait_addr", mem_addr_o, 32'h8);
    end
    force_ack = 1'b1;
    bad_data  = 1'b1;
    cyc();
    force_ack = 1'b0;
    bad_data  = 1'b0;
    auto_ack  = 1'b1;
    chk("t3_no_stale_valid", 32'(instr_valid_o), 32'h0);
    chk("t3_new_addr", mem_addr_o, 32'h100);
    cyc();
    chk("t3_first_pc", pc_o, 32'h100);
    for (int i = 0; i < 3; i++) cyc();

    // Redirect coinciding with an ack
    chk("t4_req_active", 32'(mem_req_o), 32'h1);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    cyc();
    redirect_i = 1'b0;
    chk("t4_flushed", 32'(instr_valid_o), 32'h0);
    chk("t4_req", 32'(mem_req_o), 32'h1);
    chk("t4_addr", mem_addr_o, 32'h200);
    cyc();
    chk("t4_first_pc", pc_o, 32'h200);
    for (int i = 0; i < 2; i++) cyc();

    // Reset with a full buffer
    instr_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("t5_full_valid", 32'(instr_valid_o), 32'h1);
    do_reset();
    auto_ack = 1'b1;
    cyc();
    chk("t5_restart_addr", mem_addr_o, RESET_PC);
    chk("t5_restart_req", 32'(mem_req_o), 32'h1);
    instr_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) cyc();

`ifdef INSTR_FETCH_PERF_EN
    do_reset();
    chk("perf_reset", fetch_count, 32'h0);
    instr_ready_i = 1'b1;
    auto_ack      = 1'b1;
    for (int i = 0; i < 20 && pops < 5; i++) cyc();
    chk("perf_pops", 32'(pops), 32'd5);
    chk("perf_head_live", 32'(instr_valid_o), 32'h1);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h300;
    cyc();
    redirect_i = 1'b0;
    chk("perf_count", fetch_count, 32'd5);
    do_reset();
    chk("perf_count_rst", fetch_count, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the decoder and immediate generator. Maintains the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned instructions with their PCs in a small FIFO and presents them downstream over a valid/ready handshake.
- Handles control-flow redirects from execute: flushes the buffer and drops any in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, >= 2.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- mem_req_o  output  1  memory read request; held until acked
- mem_addr_o  output  32  word address; stable while mem_req_o=1
- mem_ack_i  input  1  read complete; mem_rdata_i valid this cycle; ignored when mem_req_o=0
- mem_rdata_i  input  32  instruction word
- redirect_i  input  1  flush and restart fetch at redirect_pc_i
- redirect_pc_i  input  32  new fetch PC, word aligned
- instr_o  output  32  instruction at FIFO head
- pc_o  output  32  PC of instr_o
- instr_valid_o  output  1  FIFO non-empty
- instr_ready_i  input  1  downstream accepts head this cycle

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - mem_req_o=0, mem_addr_o=0, instr_o=0, pc_o=0, instr_valid_o=0.
  - FIFO count=0, fetch_pc=RESET_PC, state=IDLE.
- State machine: IDLE, REQ, DISCARD. mem_req_o and mem_addr_o are registered.
- free: true when count after this cycle's push/pop < FIFO_DEPTH.
- IDLE:
  - mem_req_o=0.
  - If free: next state REQ, mem_addr_o<=fetch_pc.
  - First request is presented in the cycle after rst_n rises.
- REQ (mem_req_o=1):
  - On ack with no redirect: push {fetch_pc, mem_rdata_i}; fetch_pc+=4.
  - Then, if free, stay in REQ with mem_addr_o<=new fetch_pc (back-to-back fetches); else go to IDLE.
  - No ack: hold.
- Redirect in REQ:
  - Without ack: fetch_pc<=redirect_pc_i; go to DISCARD, keeping the old address and mem_req_o=1.
  - With ack in the same cycle: data dropped; go to REQ with mem_addr_o<=redirect_pc_i.
- DISCARD:
  - On ack: drop data; go to REQ with mem_addr_o<=fetch_pc.
  - A further redirect overwrites fetch_pc; the newest redirect wins.
- Any redirect_i:
  - Clears FIFO count the same edge; instr_valid_o=0 the next cycle.
  - Takes priority over any pop or push that cycle.
  - Downstream treats a head presented during a redirect cycle as killed.
- Pop on instr_valid_o & instr_ready_i. Push and pop in the same cycle leave count unchanged.
- Push is never attempted when full; guaranteed by the one-outstanding-request rule.
- Latency: ack at cycle t, with FIFO empty, gives instr_valid_o=1 with that instr/pc at t+1.
- Hold: while instr_valid_o=1 and instr_ready_i=0, instr_o and pc_o stay stable.
- fetch_pc wraps modulo 2^32. Exactly one outstanding request at a time.

Optional Feature:
- Macro INSTR_FETCH_PERF_EN.
- Defined: adds output fetch_count_o (32 bits).
  - Reset 0.
  - Increments on each accepted pop (instr_valid_o & instr_ready_i & !redirect_i); wraps at 2^32.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, memory acks each request in the cycle it is raised, ready=1 -> mem_addr_o 0x0,0x4,0x8,... on consecutive cycles; instr_valid_o first high the cycle after first ack with pc_o=0x0, then one instruction per cycle in PC order.
- ready=0 from start -> after 2 pushes (0x0,0x4) mem_req_o drops; instr_o/pc_o hold 0x0 entry; raise ready -> one pop per cycle; request for 0x8 reissued once space frees.
- Request to 0x8 pending, redirect_i=1 with redirect_pc_i=0x100, ack arrives 3 cycles later with 0xDEADBEEF -> instr_valid_o=0 from the cycle after the redirect; 0xDEADBEEF never appears; next mem_addr_o=0x100; first output pc_o=0x100.
- redirect_i and mem_ack_i in the same cycle (redirect_pc 0x200) -> rdata dropped, FIFO empty, next request address 0x200.
- rst_n low for one cycle mid-request with FIFO holding 2 entries -> next cycle mem_req_o=0 and instr_valid_o=0; following request address=RESET_PC.
- INSTR_FETCH_PERF_EN defined, 5 accepted pops plus one head killed by redirect -> fetch_count_o=5; rst_n low -> 0.
